idu: RTL and testbench

Instruction decode stage between the instruction fetch unit and the execute unit. Accepts one fetched instruction word plus its PC per valid/ready handshake, decodes it combinationally on entry (RV32I base integer subset plus `ebreak`), and registers the decoded bundle for the execute unit. A two-entry skid buffer gives full throughput with a registered `s_ready`, so backpressure from execute never forms a combinational path back into fetch.

---
 rtl/idu_pkg.sv | 78 +++++++
 rtl/idu_decoder.sv | 147 ++++++++++++++
 rtl/idu.sv | 92 +++++++++
 tb/tb_idu.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/idu_pkg.sv
// idu_pkg: shared decode constants, ALU encodings, control-bit layout and bundle type for the decode stage
package idu_pkg;

    // Major opcodes (inst[6:0]); the low two bits are 2'b11 for every legal encoding
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    // m_ctl layout, MSB first:
    // {src_a_pc, src_b_imm, reg_wen, mem_ren, mem_wen, mem_size[1:0], mem_unsigned, branch, jal, jalr, ebreak, illegal}
    localparam int CTL_W         = 13;
    localparam int CTL_SRC_A_PC  = 12;
    localparam int CTL_SRC_B_IMM = 11;
    localparam int CTL_REG_WEN   = 10;
    localparam int CTL_MEM_REN   = 9;
    localparam int CTL_MEM_WEN   = 8;
    localparam int CTL_MEM_SIZE  = 6;
    localparam int CTL_MEM_UNS   = 5;
    localparam int CTL_BRANCH    = 4;
    localparam int CTL_JAL       = 3;
    localparam int CTL_JALR      = 2;
    localparam int CTL_EBREAK    = 1;
    localparam int CTL_ILLEGAL   = 0;

    // mem_size codes; they coincide with funct3[1:0] of loads and stores
    localparam logic [1:0] MEM_B = 2'd0;
    localparam logic [1:0] MEM_H = 2'd1;
    localparam logic [1:0] MEM_W = 2'd2;

    // Decoded bundle as held in the output and skid registers
    typedef struct packed {
        logic [31:0]      pc;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [31:0]      imm;
        logic [3:0]       alu_op;
        logic [CTL_W-1:0] ctl;
    } dec_t;

    // Integer ALU op from funct3; alt selects SUB/SRA (inst[30])
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/idu_decoder.sv
// idu_decoder: combinational RV32I (+ebreak) decode of one instruction word
//   i_inst   : instruction word
//   o_rs1/o_rs2/o_rd : register indices, 0 when the format does not use them
//   o_imm    : sign-extended immediate, 0 for R-type
//   o_alu_op : ALU operation (idu_pkg::alu_op_e)
//   o_ctl    : control bits (idu_pkg CTL_* layout)
module idu_decoder
    import idu_pkg::*;
(
    input  logic [31:0]      i_inst,
    output logic [4:0]       o_rs1,
    output logic [4:0]       o_rs2,
    output logic [4:0]       o_rd,
    output logic [31:0]      o_imm,
    output logic [3:0]       o_alu_op,
    output logic [CTL_W-1:0] o_ctl
);

    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic        w_ill;

    assign w_op    = i_inst[6:0];
    assign w_f3    = i_inst[14:12];
    assign w_f7    = i_inst[31:25];
    assign w_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
    assign w_imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign w_imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign w_imm_u = {i_inst[31:12], 12'b0};
    assign w_imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

    always_comb begin
        o_rs1    = '0;
        o_rs2    = '0;
        o_rd     = '0;
        o_imm    = '0;
        o_alu_op = ALU_ADD;
        o_ctl    = '0;
        w_ill    = 1'b0;
        case (w_op)
            OP_LUI: begin
                o_rd                 = i_inst[11:7];
                o_imm                = w_imm_u;
                o_alu_op             = ALU_PASSB;
                o_ctl[CTL_SRC_B_IMM] = 1'b1;
                o_ctl[CTL_REG_WEN]   = 1'b1;
            end
            OP_AUIPC: begin
                o_rd                 = i_inst[11:7];
                o_imm                = w_imm_u;
                o_ctl[CTL_SRC_A_PC]  = 1'b1;
                o_ctl[CTL_SRC_B_IMM] = 1'b1;
                o_ctl[CTL_REG_WEN]   = 1'b1;
            end
            OP_JAL: begin
                // ALU forms the target pc+imm; execute writes pc+4 to rd
                o_rd                 = i_inst[11:7];
                o_imm                = w_imm_j;
                o_ctl[CTL_SRC_A_PC]  = 1'b1;
                o_ctl[CTL_SRC_B_IMM] = 1'b1;
                o_ctl[CTL_REG_WEN]   = 1'b1;
                o_ctl[CTL_JAL]       = 1'b1;
            end
            OP_JALR: begin
                o_rs1                = i_inst[19:15];
                o_rd                 = i_inst[11:7];
                o_imm                = w_imm_i;
                o_ctl[CTL_SRC_B_IMM] = 1'b1;
                o_ctl[CTL_REG_WEN]   = 1'b1;
                o_ctl[CTL_JALR]      = 1'b1;
                w_ill                = w_f3 != 3'b000;
            end
            OP_BRANCH: begin
                // funct3[2:1] picks the comparison, funct3[0] is the inverted sense for execute
                o_rs1             = i_inst[19:15];
                o_rs2             = i_inst[24:20];
                o_imm             = w_imm_b;
                o_alu_op          = w_f3[2:1] == 2'b00 ? ALU_SUB : w_f3[2:1] == 2'b10 ? ALU_SLT : ALU_SLTU;
                o_ctl[CTL_BRANCH] = 1'b1;
                w_ill             = w_f3[2:1] == 2'b01;
            end
            OP_LOAD: begin
                o_rs1                          = i_inst[19:15];
                o_rd                           = i_inst[11:7];
                o_imm                          = w_imm_i;
                o_ctl[CTL_SRC_B_IMM]           = 1'b1;
                o_ctl[CTL_REG_WEN]             = 1'b1;
                o_ctl[CTL_MEM_REN]             = 1'b1;
                o_ctl[CTL_MEM_SIZE +: 2]       = w_f3[1:0];
                o_ctl[CTL_MEM_UNS]             = w_f3[2];
                w_ill                          = w_f3[1:0] > MEM_W || (w_f3[2] && w_f3[1:0] == MEM_W);
            end
            OP_STORE: begin
                o_rs1                    = i_inst[19:15];
                o_rs2                    = i_inst[24:20];
                o_imm                    = w_imm_s;
                o_ctl[CTL_SRC_B_IMM]     = 1'b1;
                o_ctl[CTL_MEM_WEN]       = 1'b1;
                o_ctl[CTL_MEM_SIZE +: 2] = w_f3[1:0];
                w_ill                    = w_f3[2] || w_f3[1:0] > MEM_W;
            end
            OP_IMM: begin
                o_rs1                = i_inst[19:15];
                o_rd                 = i_inst[11:7];
                o_imm                = w_imm_i;
                o_alu_op             = alu_from_f3(w_f3, w_f3 == 3'b101 && i_inst[30]);
                o_ctl[CTL_SRC_B_IMM] = 1'b1;
                o_ctl[CTL_REG_WEN]   = 1'b1;
                // shift-immediates reuse the funct7 field; only 0 and 0x20 (SRAI) are defined
                w_ill                = (w_f3 == 3'b001 && w_f7 != 7'h00) ||
                                       (w_f3 == 3'b101 && w_f7 != 7'h00 && w_f7 != 7'h20);
            end
            OP_OP: begin
                o_rs1              = i_inst[19:15];
                o_rs2              = i_inst[24:20];
                o_rd               = i_inst[11:7];
                o_alu_op           = alu_from_f3(w_f3, i_inst[30]);
                o_ctl[CTL_REG_WEN] = 1'b1;
                w_ill              = !(w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
            end
            OP_SYSTEM: begin
                o_ctl[CTL_EBREAK] = i_inst == INST_EBREAK;
                w_ill             = i_inst != INST_EBREAK;
            end
            default: w_ill = 1'b1;
        endcase
        // Illegal words travel downstream as a bare trap marker with no side effects
        if (w_ill) begin
            o_rs1              = '0;
            o_rs2              = '0;
            o_rd               = '0;
            o_imm              = '0;
            o_alu_op           = ALU_ADD;
            o_ctl              = '0;
            o_ctl[CTL_ILLEGAL] = 1'b1;
        end
        if (o_rd == 5'd0)
            o_ctl[CTL_REG_WEN] = 1'b0;
    end

endmodule

// File: rtl/idu.sv
// idu: instruction decode stage with a two-entry skid buffer between fetch and execute
//   clk, rst (async, active-low)
//   s_valid/s_ready/s_inst/s_pc : beat from fetch; s_ready is a flop output
//   flush                       : drop every held beat
//   m_valid/m_ready/m_pc/m_rs1/m_rs2/m_rd/m_imm/m_alu_op/m_ctl : registered decoded bundle to execute
module idu
    import idu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [31:0]     s_inst,
    input  logic [XLEN-1:0] s_pc,
    input  logic            flush,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [XLEN-1:0] m_pc,
    output logic [4:0]      m_rs1,
    output logic [4:0]      m_rs2,
    output logic [4:0]      m_rd,
    output logic [XLEN-1:0] m_imm,
    output logic [3:0]      m_alu_op,
    output logic [12:0]     m_ctl
);

    logic [4:0]       w_rs1;
    logic [4:0]       w_rs2;
    logic [4:0]       w_rd;
    logic [31:0]      w_imm;
    logic [3:0]       w_alu_op;
    logic [CTL_W-1:0] w_ctl;
    dec_t             w_in;
    logic             w_acc;
    logic             w_cons;

    dec_t r_out;
    dec_t r_skid;
    logic r_out_valid;
    logic r_skid_valid;

    idu_decoder u_dec (
        .i_inst   (s_inst),
        .o_rs1    (w_rs1),
        .o_rs2    (w_rs2),
        .o_rd     (w_rd),
        .o_imm    (w_imm),
        .o_alu_op (w_alu_op),
        .o_ctl    (w_ctl)
    );

    assign w_in   = {s_pc, w_rs1, w_rs2, w_rd, w_imm, w_alu_op, w_ctl};
    assign w_acc  = s_valid & s_ready;
    assign w_cons = r_out_valid & m_ready;

    // skid is only ever filled while out is stalled, and s_ready is low whenever
    // skid holds a beat, so skid and a new input never compete for out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out        <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_out_valid || w_cons) begin
            r_out_valid  <= r_skid_valid | w_acc;
            r_skid_valid <= 1'b0;
            if (r_skid_valid)
                r_out <= r_skid;
            else if (w_acc)
                r_out <= w_in;
        end else if (w_acc) begin
            r_skid_valid <= 1'b1;
            r_skid       <= w_in;
        end
    end

    assign s_ready  = ~r_skid_valid;
    assign m_valid  = r_out_valid;
    assign m_pc     = r_out.pc;
    assign m_rs1    = r_out.rs1;
    assign m_rs2    = r_out.rs2;
    assign m_rd     = r_out.rd;
    assign m_imm    = r_out.imm;
    assign m_alu_op = r_out.alu_op;
    assign m_ctl    = r_out.ctl;

endmodule

// File: tb/tb_idu.sv
// tb_idu: directed self-checking bench for the idu decode stage
module tb_idu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_inst = 32'h0;
    logic [31:0] s_pc = 32'h0;
    logic        flush = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_pc;
    logic [4:0]  m_rs1;
    logic [4:0]  m_rs2;
    logic [4:0]  m_rd;
    logic [31:0] m_imm;
    logic [3:0]  m_alu_op;
    logic [12:0] m_ctl;

    int errors = 0;
    int checks = 0;

    idu #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_inst   (s_inst),
        .s_pc     (s_pc),
        .flush    (flush),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_pc     (m_pc),
        .m_rs1    (m_rs1),
        .m_rs2    (m_rs2),
        .m_rd     (m_rd),
        .m_imm    (m_imm),
        .m_alu_op (m_alu_op),
        .m_ctl    (m_ctl)
    );

    always #5 clk = ~clk;

    // Hand-decoded vectors: inst, rs1, rs2, rd, imm, alu_op, ctl
    localparam int N = 13;
    logic [31:0] v_inst [N] = '{32'h00500093, 32'h123450B7, 32'hFE000EE3, 32'h00100073, 32'hFFFFFFFF,
                                32'h0080A103, 32'h0020A223, 32'h402081B3, 32'h00000013, 32'h00500091,
                                32'h00001297, 32'h4030D093, 32'h0020E463};
    logic [4:0]  v_rs1  [N] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 5'd1, 5'd1};
    logic [4:0]  v_rs2  [N] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd2, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd2};
    logic [4:0]  v_rd   [N] = '{5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 5'd3, 5'd0, 5'd0, 5'd5, 5'd1, 5'd0};
    logic [31:0] v_imm  [N] = '{32'd5, 32'h12345000, 32'hFFFFFFFC, 32'd0, 32'd0, 32'd8, 32'd4, 32'd0,
                                32'd0, 32'd0, 32'h00001000, 32'h00000403, 32'd8};
    logic [3:0]  v_alu  [N] = '{4'd0, 4'd10, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd7, 4'd4};
    logic [12:0] v_ctl  [N] = '{13'h0C00, 13'h0C00, 13'h0010, 13'h0002, 13'h0001, 13'h0E80, 13'h0980,
                                13'h0400, 13'h0800, 13'h0001, 13'h1C00, 13'h0C00, 13'h0010};

    task automatic test_reset;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs: m_valid=%b s_ready=%b, want 0 1", m_valid, s_ready);
        end
        checks++;
        if ({m_pc, m_rs1, m_rs2, m_rd, m_imm, m_alu_op, m_ctl} !== '0) begin
            errors++;
            $display("FAIL reset_data: pc=%h imm=%h ctl=%h, want all 0", m_pc, m_imm, m_ctl);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // One instruction per cycle with m_ready high: each result appears the cycle after it is offered
    task automatic test_decode;
        m_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            s_valid = 1'b1;
            s_inst  = v_inst[i];
            s_pc    = 32'h1000 + 32'(4 * i);
            @(posedge clk);
            #1;
            checks++;
            if ({m_valid, m_pc, m_rs1, m_rs2, m_rd, m_imm, m_alu_op, m_ctl} !==
                {1'b1, 32'h1000 + 32'(4 * i), v_rs1[i], v_rs2[i], v_rd[i], v_imm[i], v_alu[i], v_ctl[i]}) begin
                errors++;
                $display("FAIL decode[%0d] inst=%h: got v=%b pc=%h rs1=%0d rs2=%0d rd=%0d imm=%h alu=%0d ctl=%h, want v=1 pc=%h rs1=%0d rs2=%0d rd=%0d imm=%h alu=%0d ctl=%h",
                         i, v_inst[i], m_valid, m_pc, m_rs1, m_rs2, m_rd, m_imm, m_alu_op, m_ctl,
                         32'h1000 + 32'(4 * i), v_rs1[i], v_rs2[i], v_rd[i], v_imm[i], v_alu[i], v_ctl[i]);
            end
        end
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL decode_drain: m_valid=%b, want 0", m_valid);
        end
    endtask

    task automatic test_back_to_back;
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_inst  = 32'h00000013;
        s_pc    = 32'h0;
        @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b1 || m_pc !== 32'h0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_first: m_valid=%b m_pc=%h s_ready=%b, want 1 0 1", m_valid, m_pc, s_ready);
        end
        s_pc = 32'h4;
        @(posedge clk);
        #1;
        checks++;
        if (s_ready !== 1'b0 || m_pc !== 32'h0) begin
            errors++;
            $display("FAIL stall_full: s_ready=%b m_pc=%h, want 0 0", s_ready, m_pc);
        end
        s_pc = 32'h8;
        @(posedge clk);
        #1;
        checks++;
        if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_pc !== 32'h0) begin
            errors++;
            $display("FAIL stall_hold: s_ready=%b m_valid=%b m_pc=%h, want 0 1 0", s_ready, m_valid, m_pc);
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b1 || m_pc !== 32'h4 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_1: m_valid=%b m_pc=%h s_ready=%b, want 1 4 1", m_valid, m_pc, s_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b1 || m_pc !== 32'h8) begin
            errors++;
            $display("FAIL release_2: m_valid=%b m_pc=%h, want 1 8", m_valid, m_pc);
        end
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL release_end: m_valid=%b, want 0", m_valid);
        end
    endtask

    task automatic test_flush;
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_inst  = 32'h00500093;
        s_pc    = 32'h10;
        @(posedge clk);
        #1 s_pc = 32'h14;
        @(posedge clk);
        #1 s_pc = 32'h18;
        flush = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_full: m_valid=%b s_ready=%b, want 0 1", m_valid, s_ready);
        end
        s_pc = 32'h20;
        @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop_input: m_valid=%b, want 0", m_valid);
        end
        flush = 1'b0;
        s_pc  = 32'h24;
        @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b1 || m_pc !== 32'h24) begin
            errors++;
            $display("FAIL flush_recover: m_valid=%b m_pc=%h, want 1 24", m_valid, m_pc);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset;
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_inst  = 32'h123450B7;
        s_pc    = 32'h40;
        @(posedge clk);
        #1 s_pc = 32'h44;
        @(posedge clk);
        #1 s_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset: m_valid=%b s_ready=%b, want 1 0", m_valid, s_ready);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_pc !== 32'h0 || m_ctl !== 13'h0) begin
            errors++;
            $display("FAIL async_reset: m_valid=%b s_ready=%b m_pc=%h m_ctl=%h, want 0 1 0 0",
                     m_valid, s_ready, m_pc, m_ctl);
        end
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
